// File: rtl/mult_sched_pkg.sv
// Shared types and constants for the multiplier scheduler.
package mult_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int BITS_DEFAULT = 64;
    localparam int LOAD_CYCLES  = 1;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first set request at or above rr_ptr, wrapping.
// Purely combinational; grant is one-hot or zero when nothing requests.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  rr_ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  grant_id
);

    logic           found;
    logic [IDW:0]   pos;
    logic [IDW-1:0] idx;

    always_comb begin
        grant    = '0;
        grant_id = '0;
        found    = 1'b0;
        pos      = '0;
        idx      = '0;
        for (int off = 0; off < NREQ; off++) begin
            pos = {1'b0, rr_ptr} + (IDW+1)'(off);
            if (pos >= (IDW+1)'(NREQ))
                pos = pos - (IDW+1)'(NREQ);
            idx = pos[IDW-1:0];
            if (!found && req[idx]) begin
                found       = 1'b1;
                grant[idx]  = 1'b1;
                grant_id    = idx;
            end
        end
    end

endmodule

// File: rtl/mult_scheduler.sv
// Shares one serial shift-add multiplier among NREQ requesters, round-robin.
// Result appears 66 cycles after accept; no new accept until the response is taken.
module mult_scheduler
    import mult_sched_pkg::*;
#(
    parameter int BITS = BITS_DEFAULT,
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*BITS-1:0] req_a,
    input  logic [NREQ*BITS-1:0] req_b,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IDW-1:0]       rsp_id,
    output logic [2*BITS-1:0]    rsp_product,
    output logic                 busy,
    output logic                 mul_rst_n,
    output logic                 mul_w_en,
    output logic [BITS-1:0]      mul_a,
    output logic [BITS-1:0]      mul_b,
    input  logic                 mul_ok,
    input  logic [2*BITS-1:0]    mul_product
);

    state_t          state, state_nxt;
    logic [IDW-1:0]  rr_ptr;
    logic [IDW-1:0]  cur_id;
    logic [NREQ-1:0] grant;
    logic [IDW-1:0]  grant_id;
    logic            accept;

    rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
        .req      (req_valid),
        .rr_ptr   (rr_ptr),
        .grant    (grant),
        .grant_id (grant_id)
    );

    assign req_ready = (state == IDLE) ? grant : '0;
    assign accept    = |(req_valid & req_ready);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept)    state_nxt = LOAD;
            LOAD:                   state_nxt = RUN;
            RUN:     if (mul_ok)    state_nxt = DONE;
            DONE:    if (rsp_ready) state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    // Multiplier pins are decoded from the next state so they are flop outputs
    // that line up with the LOAD cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            busy        <= 1'b0;
            mul_rst_n   <= 1'b0;
            mul_w_en    <= 1'b0;
            mul_a       <= '0;
            mul_b       <= '0;
            cur_id      <= '0;
            rr_ptr      <= '0;
            rsp_valid   <= 1'b0;
            rsp_id      <= '0;
            rsp_product <= '0;
        end else begin
            state     <= state_nxt;
            busy      <= (state_nxt != IDLE);
            mul_rst_n <= (state_nxt != LOAD);
            mul_w_en  <= (state_nxt == LOAD);
            if (accept) begin
                mul_a  <= req_a[grant_id*BITS +: BITS];
                mul_b  <= req_b[grant_id*BITS +: BITS];
                cur_id <= grant_id;
                rr_ptr <= (grant_id == IDW'(NREQ-1)) ? '0 : grant_id + 1'b1;
            end
            if (state == RUN && mul_ok) begin
                rsp_product <= mul_product;
                rsp_id      <= cur_id;
                rsp_valid   <= 1'b1;
            end else if (state == DONE && rsp_ready) begin
                rsp_valid   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mult_scheduler.sv
// Bench for mult_scheduler: serial multiplier stand-in, transaction-level
// timing model checked every cycle, plus directed literal checks.
module tb_mult_scheduler;

    localparam int BITS = 64;
    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic                 clk = 1'b0;
    logic                 reset_n = 1'b0;
    logic [NREQ-1:0]      req_valid = '0;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*BITS-1:0] req_a = '0;
    logic [NREQ*BITS-1:0] req_b = '0;
    logic                 rsp_valid;
    logic                 rsp_ready = 1'b1;
    logic [IDW-1:0]       rsp_id;
    logic [2*BITS-1:0]    rsp_product;
    logic                 busy;
    logic                 mul_rst_n;
    logic                 mul_w_en;
    logic [BITS-1:0]      mul_a;
    logic [BITS-1:0]      mul_b;
    logic                 mul_ok;
    logic [2*BITS-1:0]    mul_product;

    always #5 clk = ~clk;

    mult_scheduler #(.BITS(BITS), .NREQ(NREQ), .IDW(IDW)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_a       (req_a),
        .req_b       (req_b),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_id      (rsp_id),
        .rsp_product (rsp_product),
        .busy        (busy),
        .mul_rst_n   (mul_rst_n),
        .mul_w_en    (mul_w_en),
        .mul_a       (mul_a),
        .mul_b       (mul_b),
        .mul_ok      (mul_ok),
        .mul_product (mul_product)
    );

    // Serial shift-add multiplier: cleared only via its reset pin, one bit per clock.
    int          mcnt = 0;
    logic [63:0] ma = '0, mb = '0;
    logic [127:0] macc = '0;

    always @(posedge clk) begin
        if (!mul_rst_n) begin
            mcnt <= 0;
            macc <= '0;
            if (mul_w_en) begin
                ma <= mul_a;
                mb <= mul_b;
            end
        end else if (mcnt < 64) begin
            if (mb[mcnt]) macc <= macc + ({64'b0, ma} << mcnt);
            mcnt <= mcnt + 1;
        end
    end
    assign mul_ok      = (mcnt == 64);
    assign mul_product = macc;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: one job in flight, result due 66 cycles after
    // the accept edge, retired on the response handshake.
    bit           m_busy = 0;
    bit           m_fresh = 1;
    int           m_age = 0;
    int           m_ptr = 0;
    int           m_id = 0;
    int           r_id = 0;
    logic [63:0]  la = '0, lb = '0;
    logic [127:0] m_prod = '0, r_prod = '0;
    logic [NREQ-1:0] eg;
    int           g;
    bit           exp_rv;
    int           acc_log[$];

    always @(negedge clk) begin
        if (!reset_n) begin
            check("rst_req_ready", req_ready, 0);
            check("rst_rsp_valid", rsp_valid, 0);
            check("rst_busy", busy, 0);
            check("rst_mul_rst_n", mul_rst_n, 0);
            check("rst_mul_w_en", mul_w_en, 0);
            check("rst_mul_a", mul_a, 0);
            check("rst_mul_b", mul_b, 0);
            check("rst_rsp_id", rsp_id, 0);
            check("rst_rsp_product", rsp_product, 0);
            m_busy = 0; m_fresh = 1; m_age = 0; m_ptr = 0;
            la = '0; lb = '0; r_id = 0; r_prod = '0;
        end else begin
            eg = '0;
            g  = -1;
            if (!m_busy) begin
                for (int off = 0; off < NREQ; off++) begin
                    if (g < 0 && req_valid[(m_ptr + off) % NREQ]) g = (m_ptr + off) % NREQ;
                end
                if (g >= 0) eg[g] = 1'b1;
            end
            exp_rv = m_busy && (m_age >= 66);
            if (exp_rv) begin
                r_id   = m_id;
                r_prod = m_prod;
            end
            check("req_ready", req_ready, eg);
            check("ready_onehot0", $onehot0(req_ready), 1);
            check("rsp_valid", rsp_valid, exp_rv);
            check("busy", busy, m_busy);
            check("mul_w_en", mul_w_en, m_busy && m_age == 0);
            check("mul_rst_n", mul_rst_n, !(m_fresh || (m_busy && m_age == 0)));
            check("mul_a", mul_a, la);
            check("mul_b", mul_b, lb);
            check("rsp_id", rsp_id, r_id);
            check("rsp_product", rsp_product, r_prod);

            m_fresh = 0;
            if (m_busy) begin
                if (exp_rv && rsp_ready) m_busy = 0;
                else m_age++;
            end else if (g >= 0) begin
                m_busy = 1;
                m_age  = 0;
                m_id   = g;
                la     = req_a[g*BITS +: BITS];
                lb     = req_b[g*BITS +: BITS];
                m_prod = {64'b0, la} * {64'b0, lb};
                m_ptr  = (g + 1) % NREQ;
                acc_log.push_back(g);
            end
        end
    end

    task automatic run_job(input int id, input logic [63:0] a, input logic [63:0] b,
                           input string tag, input logic [127:0] exp);
        bit ok;
        int lat;
        req_a[id*BITS +: BITS] = a;
        req_b[id*BITS +: BITS] = b;
        req_valid[id] = 1'b1;
        ok = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (req_ready[id]) begin ok = 1; break; end
        end
        check({tag, "_granted"}, ok, 1);
        @(posedge clk);
        #1 req_valid[id] = 1'b0;
        ok  = 0;
        lat = 0;
        for (int k = 1; k <= 200; k++) begin
            @(posedge clk);
            #1;
            if (rsp_valid) begin ok = 1; lat = k; break; end
        end
        check({tag, "_rsp_seen"}, ok, 1);
        check({tag, "_latency"}, lat, 66);
        check({tag, "_product"}, rsp_product, exp);
        check({tag, "_id"}, rsp_id, id);
    endtask

    task automatic wait_idle(input string tag);
        bit ok = 0;
        for (int k = 0; k < 300; k++) begin
            @(posedge clk);
            #1;
            if (!busy) begin ok = 1; break; end
        end
        check({tag, "_idle"}, ok, 1);
    endtask

    logic [127:0] hold_prod;
    logic [IDW-1:0] hold_id;
    bit ok_w;
    int base;

    initial begin
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        #1 check("post_rst_mul_rst_n_low", mul_rst_n, 0);
        @(posedge clk);
        #1 check("mul_rst_n_after_rst", mul_rst_n, 1);

        // Fairness: everyone valid from pointer 0
        for (int i = 0; i < NREQ; i++) begin
            req_a[i*BITS +: BITS] = 64'(i + 2);
            req_b[i*BITS +: BITS] = 64'(i * 1000 + 17);
        end
        acc_log.delete();
        req_valid = '1;
        ok_w = 0;
        for (int k = 0; k < 600; k++) begin
            @(posedge clk);
            #1;
            if (acc_log.size() >= 5) begin ok_w = 1; break; end
        end
        req_valid = '0;
        check("fair_five_accepts", ok_w, 1);
        if (acc_log.size() >= 5) begin
            check("fair_order0", acc_log[0], 0);
            check("fair_order1", acc_log[1], 1);
            check("fair_order2", acc_log[2], 2);
            check("fair_order3", acc_log[3], 3);
            check("fair_order4", acc_log[4], 0);
        end
        wait_idle("fair");

        run_job(0, 64'd3, 64'd5, "single", 128'd15);
        run_job(1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, "max",
                128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001);
        run_job(2, 64'd7, 64'd9, "b2b_1", 128'd63);
        run_job(2, 64'd2, 64'd0, "b2b_2", 128'd0);

        // Back-pressure with other requesters waiting
        rsp_ready = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            req_a[i*BITS +: BITS] = 64'(i + 10);
            req_b[i*BITS +: BITS] = 64'(i + 20);
        end
        req_valid = '1;
        ok_w = 0;
        for (int k = 0; k < 300; k++) begin
            @(posedge clk);
            #1;
            if (rsp_valid) begin ok_w = 1; break; end
        end
        check("bp_rsp_seen", ok_w, 1);
        hold_prod = rsp_product;
        hold_id   = rsp_id;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            check("bp_valid_held", rsp_valid, 1);
            check("bp_product_held", rsp_product, hold_prod);
            check("bp_id_held", rsp_id, hold_id);
            check("bp_ready_zero", req_ready, 0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 req_valid = '0;
        check("bp_released", rsp_valid, 0);
        wait_idle("bp");

        // Reset mid-RUN aborts the job
        req_a[1*BITS +: BITS] = 64'd11;
        req_b[1*BITS +: BITS] = 64'd13;
        req_valid[1] = 1'b1;
        ok_w = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (req_ready[1]) begin ok_w = 1; break; end
        end
        check("rstrun_granted", ok_w, 1);
        @(posedge clk);
        #1 req_valid[1] = 1'b0;
        repeat (30) @(posedge clk);
        #1 reset_n = 1'b0;
        #1;
        check("rstrun_busy", busy, 0);
        check("rstrun_rsp_valid", rsp_valid, 0);
        check("rstrun_mul_w_en", mul_w_en, 0);
        check("rstrun_mul_rst_n", mul_rst_n, 0);
        @(posedge clk);
        #1 reset_n = 1'b1;
        @(posedge clk);
        #1;
        run_job(1, 64'd6, 64'd7, "after_rst", 128'd42);

        // Randomized traffic, checked by the model every cycle
        base = acc_log.size();
        for (int k = 0; k < 5000; k++) begin
            @(posedge clk);
            #1;
            req_valid = NREQ'($urandom_range(0, 15));
            for (int i = 0; i < NREQ; i++) begin
                case ($urandom_range(0, 7))
                    0:       req_a[i*BITS +: BITS] = '1;
                    1:       req_a[i*BITS +: BITS] = '0;
                    default: req_a[i*BITS +: BITS] = {$urandom, $urandom};
                endcase
                req_b[i*BITS +: BITS] = ($urandom_range(0, 7) == 0) ? '1 : {$urandom, $urandom};
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            if (acc_log.size() - base >= 25) break;
        end
        check("rand_25_jobs", acc_log.size() - base >= 25, 1);
        req_valid = '0;
        rsp_ready = 1'b1;
        wait_idle("rand");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
